pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32I core. Merges per-stage stall requests into a
//  per-stage stall vector for the pipeline registers, and arbitrates the ID-stage redirect
//  (jump/branch) against in-flight instruction fetches. Drives pc_reg (PC write) and if_id (flush).

---
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline sequencer bundle: stall/redirect requests from the stages and
// the stall vector, PC redirect and perf counter returned to them.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              if_stall_req;
    logic              id_stall_req;
    logic              ex_stall_req;
    logic              mem_stall_req;
    logic              jump_i;
    logic [ADDR_W-1:0] jpc_i;
    logic              perf_clr;
    logic [5:0]        stall_o;
    logic              flush_o;
    logic              pc_we_o;
    logic [ADDR_W-1:0] pc_new_o;
    logic              redir_pend_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
        output jump_i, jpc_i, perf_clr,
        input  stall_o, flush_o, pc_we_o, pc_new_o, redir_pend_o, stall_cnt_o
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req,
        input  jump_i, jpc_i, perf_clr,
        output stall_o, flush_o, pc_we_o, pc_new_o, redir_pend_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall vector merge, ID redirect
// arbitration against outstanding fetches, and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_cnt;

    logic [5:0]        w_stall;
    logic              w_accept;
    logic              w_pc_we;
    logic              w_flush;
    logic [ADDR_W-1:0] w_pc_new;

    // Stall vector: the most downstream requesting stage freezes itself and everything upstream.
    always_comb begin
        w_stall = 6'b000000;
        if (rst) begin
            w_stall = 6'b000000;
        end else if (bus.mem_stall_req) begin
            w_stall = 6'b011111;
        end else if (bus.ex_stall_req) begin
            w_stall = 6'b001111;
        end else if (bus.id_stall_req) begin
            w_stall = 6'b000111;
        end else if (bus.if_stall_req) begin
            w_stall = 6'b000011;
        end else begin
            w_stall = 6'b000000;
        end
    end

    // A held ID stage re-presents its jump next cycle, so only an advancing ID is accepted.
    assign w_accept = !rst && (r_state == ST_RUN) && bus.jump_i && !w_stall[2];

    // Redirect outputs: fire now if the fetch port is free, else from the latched target later.
    always_comb begin
        w_pc_we  = 1'b0;
        w_flush  = 1'b0;
        w_pc_new = {ADDR_W{1'b0}};
        if (rst) begin
            w_pc_we  = 1'b0;
            w_flush  = 1'b0;
            w_pc_new = {ADDR_W{1'b0}};
        end else if (r_state == ST_WAIT) begin
            if (!bus.if_stall_req) begin
                w_pc_we  = 1'b1;
                w_flush  = 1'b1;
                w_pc_new = r_target;
            end else begin
                w_pc_we  = 1'b0;
                w_flush  = 1'b0;
                w_pc_new = {ADDR_W{1'b0}};
            end
        end else if (w_accept && !bus.if_stall_req) begin
            w_pc_we  = 1'b1;
            w_flush  = 1'b1;
            w_pc_new = bus.jpc_i;
        end else begin
            w_pc_we  = 1'b0;
            w_flush  = 1'b0;
            w_pc_new = {ADDR_W{1'b0}};
        end
    end

    // Redirect FSM; reset drops any pending target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_target <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && bus.if_stall_req) begin
                        r_target <= bus.jpc_i;
                        r_state  <= ST_WAIT;
                    end else begin
                        r_state  <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (!bus.if_stall_req) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_target <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of cycles with the PC held; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (bus.perf_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_stall[0] && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.stall_o      = w_stall;
    assign bus.flush_o      = w_flush;
    assign bus.pc_we_o      = w_pc_we;
    assign bus.pc_new_o     = w_pc_new;
    assign bus.redir_pend_o = !rst && (r_state == ST_WAIT);
    assign bus.stall_cnt_o  = r_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then randomized traffic,
// checked against a queue-based reference model of the sequencing rules.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(32), .CNT_W(32)) bus ();
    pipe_ctrl_if #(.ADDR_W(32), .CNT_W(4))  bus4 ();

    pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    pipe_ctrl #(.ADDR_W(32), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic        we;
        logic [31:0] pcn;
        logic        pend;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_pend[$];
    longint      m_cnt  = 0;
    longint      m_cnt4 = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the reference model's expected response for that cycle.
    task automatic drive(input bit ifs, input bit ids, input bit exs, input bit mems,
                         input bit jmp, input logic [31:0] jpc, input bit clr, input bit rs);
        exp_t e;
        int   depth;
        @(posedge clk);
        #2;
        rst = rs;
        bus.if_stall_req = ifs;  bus4.if_stall_req = ifs;
        bus.id_stall_req = ids;  bus4.id_stall_req = ids;
        bus.ex_stall_req = exs;  bus4.ex_stall_req = exs;
        bus.mem_stall_req = mems; bus4.mem_stall_req = mems;
        bus.jump_i = jmp;        bus4.jump_i = jmp;
        bus.jpc_i = jpc;         bus4.jpc_i = jpc;
        bus.perf_clr = clr;      bus4.perf_clr = clr;

        e = '0;
        e.cnt  = m_cnt[31:0];
        e.cnt4 = m_cnt4[3:0];
        depth = mems ? 5 : exs ? 4 : ids ? 3 : ifs ? 2 : 0;
        if (rs) begin
            m_pend.delete();
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            e.stall = 6'((1 << depth) - 1);
            if (m_pend.size() > 0) begin
                e.pend = 1'b1;
                if (!ifs) begin
                    e.we = 1'b1; e.flush = 1'b1; e.pcn = m_pend.pop_front();
                end
            end else if (jmp && depth < 3) begin
                if (!ifs) begin
                    e.we = 1'b1; e.flush = 1'b1; e.pcn = jpc;
                end else begin
                    m_pend.push_back(jpc);
                end
            end
            if (clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (depth > 0) begin
                if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    // Monitor: compares every expected cycle mid-period.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall_o",      64'(bus.stall_o),      64'(e.stall));
                chk("flush_o",      64'(bus.flush_o),      64'(e.flush));
                chk("pc_we_o",      64'(bus.pc_we_o),      64'(e.we));
                chk("pc_new_o",     64'(bus.pc_new_o),     64'(e.pcn));
                chk("redir_pend_o", 64'(bus.redir_pend_o), 64'(e.pend));
                chk("stall_cnt_o",  64'(bus.stall_cnt_o),  64'(e.cnt));
                chk("stall_cnt4_o", 64'(bus4.stall_cnt_o), 64'(e.cnt4));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.if_stall_req = 1'b0; bus.id_stall_req = 1'b0; bus.ex_stall_req = 1'b0;
        bus.mem_stall_req = 1'b0; bus.jump_i = 1'b0; bus.jpc_i = 32'h0; bus.perf_clr = 1'b0;
        bus4.if_stall_req = 1'b0; bus4.id_stall_req = 1'b0; bus4.ex_stall_req = 1'b0;
        bus4.mem_stall_req = 1'b0; bus4.jump_i = 1'b0; bus4.jpc_i = 32'h0; bus4.perf_clr = 1'b0;
        repeat (2) @(posedge clk);

        drive(1, 1, 1, 1, 1, 32'h40, 0, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 1);
        idle(1);
        // stall priority
        drive(0, 1, 0, 1, 0, 32'h0, 0, 0);
        drive(0, 1, 0, 0, 0, 32'h0, 0, 0);
        drive(1, 0, 1, 0, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
        // immediate redirect
        drive(0, 0, 0, 0, 1, 32'h100, 0, 0);
        // redirect waiting on fetch, jump ignored while pending
        drive(1, 0, 0, 0, 1, 32'h200, 0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
        drive(1, 1, 1, 0, 1, 32'h444, 0, 0);
        drive(0, 0, 1, 0, 1, 32'h999, 0, 0);
        idle(1);
        // jump blocked by EX, accepted once EX drops
        drive(0, 0, 1, 0, 1, 32'h300, 0, 0);
        drive(0, 0, 1, 0, 1, 32'h300, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h300, 0, 0);
        // reset mid-WAIT drops the pending redirect
        drive(1, 0, 0, 0, 1, 32'h500, 0, 0);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 1);
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        idle(1);
        // counter: 10 stall cycles, clear, then saturate the 4-bit copy
        drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
        idle(1);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 0, 0, 32'h0, 0, 0);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 40, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 99) < 2,  $urandom_range(0, 199) < 1);
        end
        idle(4);
        repeat (3) @(posedge clk);
        chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
